// File: rtl/spi_slave_trx_fifo_pkg.sv
// Shared definitions for the SPI slave transceiver: char width limit,
// SPI mode encodings ({CPOL,CPHA}) and FSM state codes.
package spi_slave_trx_fifo_pkg;

    localparam int NBITS_CHAR_LEN_MAX = 32;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with flush and occupancy count; a push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module spi_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/spi_slave_trx_fifo.sv
// SPI slave transceiver (all modes, runtime char length, MSB/LSB first) with TX/RX FIFOs.
// Define SPIS_ERR_STATUS_EN to enable the sticky S_ERR_UNDER/S_ERR_OVER flags.
module spi_slave_trx_fifo
    import spi_slave_trx_fifo_pkg::*;
#(
    parameter  int CHAR_NBITS = NBITS_CHAR_LEN_MAX,
    parameter  int FIFO_DEPTH = 8,
    localparam int LW = $clog2(CHAR_NBITS),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_CSPOL,
    input  logic                  S_REV,
    input  logic [LW-1:0]         S_CHAR_LEN,
    input  logic [CHAR_NBITS-1:0] S_TX_DATA,
    input  logic                  S_TX_VALID,
    output logic                  S_TX_READY,
    output logic [CHAR_NBITS-1:0] S_RX_DATA,
    output logic                  S_RX_VALID,
    input  logic                  S_RX_READY,
    output logic [AW:0]           S_TX_LEVEL,
    output logic [AW:0]           S_RX_LEVEL,
    output logic                  S_CHAR_DONE,
    output logic                  S_ERR_UNDER,
    output logic                  S_ERR_OVER,
    input  logic                  S_ERR_CLR,
    input  logic                  S_SPI_CS,
    input  logic                  S_SPI_SCK,
    input  logic                  S_SPI_MOSI,
    output logic                  S_SPI_MISO
);

    logic [1:0]            cs_q, mosi_q;
    logic [2:0]            sck_q;
    logic                  cpol_q, cpha_q, rev_q, push_q;
    logic [LW-1:0]         len_q, cnt_q, len_in, bit_idx;
    logic [CHAR_NBITS-1:0] tx_sh_q, rx_sh_q, rx_next, tx_dout;
    state_t                state_q, state_d;
    logic                  active, sck_rise, sck_fall, sample_edge, last_bit, miso_bit;
    logic                  tx_full, tx_empty, rx_full, rx_empty, under_evt, over_evt;

    assign active   = S_ENABLE & (cs_q[1] == S_CSPOL);
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign bit_idx  = rev_q ? (len_q - cnt_q) : cnt_q;
    assign last_bit = (cnt_q == len_q);

    always_comb begin
        len_in = S_CHAR_LEN;
        if (S_CHAR_LEN < LW'(3))                  len_in = LW'(3);
        else if (int'(S_CHAR_LEN) > CHAR_NBITS - 1) len_in = LW'(CHAR_NBITS - 1);
    end

    always_comb begin
        case ({cpol_q, cpha_q})
            SPI_MODE0, SPI_MODE3: sample_edge = sck_rise;
            default:              sample_edge = sck_fall;
        endcase
    end

    always_comb begin
        rx_next          = rx_sh_q;
        rx_next[bit_idx] = mosi_q[1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (active) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (sample_edge && last_bit) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
        if (!active) state_d = ST_IDLE;
    end

    // MISO advances just after each sample edge, so with SYSCLK >= 6x SCK the
    // next bit settles well before the master's next capture edge.
    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            cs_q    <= '0;
            sck_q   <= '0;
            mosi_q  <= '0;
            state_q <= ST_IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            rev_q   <= 1'b0;
            len_q   <= LW'(3);
            cnt_q   <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            push_q  <= 1'b0;
        end else begin
            cs_q    <= {cs_q[0], S_SPI_CS};
            sck_q   <= {sck_q[1:0], S_SPI_SCK};
            mosi_q  <= {mosi_q[0], S_SPI_MOSI};
            state_q <= state_d;
            push_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cpol_q <= S_CPOL;
                    cpha_q <= S_CPHA;
                    rev_q  <= S_REV;
                    len_q  <= len_in;
                    cnt_q  <= '0;
                end
                ST_LOAD: begin
                    tx_sh_q <= tx_empty ? '0 : tx_dout;
                    rx_sh_q <= '0;
                    cnt_q   <= '0;
                end
                ST_SHIFT: begin
                    if (active && sample_edge) begin
                        rx_sh_q <= rx_next;
                        cnt_q   <= cnt_q + LW'(1);
                        push_q  <= last_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outside SHIFT the TX head is presented so CPHA=0 has bit 0 out before the first edge.
    assign miso_bit    = (state_q == ST_SHIFT) ? tx_sh_q[bit_idx] : (tx_dout[bit_idx] & ~tx_empty);
    assign S_SPI_MISO  = active ? miso_bit : 1'bz;
    assign S_CHAR_DONE = push_q;
    assign S_TX_READY  = ~tx_full;
    assign S_RX_VALID  = ~rx_empty;
    assign under_evt   = (state_q == ST_LOAD) & tx_empty;
    assign over_evt    = push_q & rx_full & ~S_RX_READY;

    spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (S_SYSCLK),
        .rst_n_i (S_RESETN),
        .flush_i (~S_ENABLE),
        .push_i  (S_TX_VALID),
        .din_i   (S_TX_DATA),
        .pop_i   (state_q == ST_LOAD),
        .dout_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (S_TX_LEVEL)
    );

    spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (S_SYSCLK),
        .rst_n_i (S_RESETN),
        .flush_i (~S_ENABLE),
        .push_i  (push_q),
        .din_i   (rx_sh_q),
        .pop_i   (S_RX_READY),
        .dout_o  (S_RX_DATA),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (S_RX_LEVEL)
    );

`ifdef SPIS_ERR_STATUS_EN
    logic err_under_q, err_over_q;

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            err_under_q <= under_evt | (err_under_q & ~S_ERR_CLR);
            err_over_q  <= over_evt  | (err_over_q  & ~S_ERR_CLR);
        end
    end

    assign S_ERR_UNDER = err_under_q;
    assign S_ERR_OVER  = err_over_q;
`else
    logic unused_err;
    assign unused_err  = &{1'b0, S_ERR_CLR, under_evt, over_evt};
    assign S_ERR_UNDER = 1'b0;
    assign S_ERR_OVER  = 1'b0;
`endif

endmodule
